// File: rtl/dcache_refill_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dcache_refill_ctrl_pkg                                          |
// | Desc   : State encoding and refill geometry for the dcache miss handler  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package dcache_refill_ctrl_pkg;

    localparam int unsigned c_dcache_fill_words = 2;
    localparam logic [31:0] c_word1_offset      = 32'((c_dcache_fill_words - 1) * 4);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ0   = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_REQ1   = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_FILL   = 3'd5,
        ST_SETTLE = 3'd6
    } state_e;

    // Second word of the line pair; plain 32-bit add so the top word wraps to 0.
    function automatic logic [31:0] word1_addr(input logic [31:0] base);
        return base + c_word1_offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dcache_refill_ctrl                                              |
// | Desc   : Load-miss handler: fetches two words over valid/ready, fills     |
// |          the dcache and holds the pipeline until the line is present    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module dcache_refill_ctrl
    import dcache_refill_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_r_en,
    input  logic [31:0]      cpu_r_addr,
    input  logic             cache_hit,
    output logic             stall,
    output logic             fill_en,
    output logic [31:0]      fill_addr,
    output logic [31:0]      fill_data0,
    output logic [31:0]      fill_data1,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int c_to_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            r_state;
    state_e            w_next_state;
    logic [31:0]       r_base;
    logic [31:0]       r_data0;
    logic [31:0]       r_data1;
    logic [c_to_w-1:0] r_to_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic              w_miss;
    logic              w_in_wait;
    logic              w_to_expire;
    // The byte offset inside the word never changes which two words are fetched.
    logic [1:0]        w_unused_addr_lo;

    assign w_unused_addr_lo = cpu_r_addr[1:0];
    assign w_miss           = cpu_r_en & ~cache_hit;
    assign w_in_wait        = (r_state == ST_WAIT0) || (r_state == ST_WAIT1);
    assign w_to_expire      = (r_to_cnt == c_to_w'(TIMEOUT - 1));

    assign stall         = (r_state != ST_IDLE) | w_miss;
    assign fill_en       = (r_state == ST_FILL);
    assign mem_req_valid = (r_state == ST_REQ0) || (r_state == ST_REQ1);
    assign mem_req_addr  = (r_state == ST_REQ1) ? word1_addr(r_base) : r_base;
    assign fill_addr     = r_base;
    assign fill_data0    = r_data0;
    assign fill_data1    = r_data1;
    assign miss_cnt      = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_miss)         w_next_state = ST_REQ0;
            ST_REQ0:   if (mem_req_ready)  w_next_state = ST_WAIT0;
            ST_WAIT0: begin
                if (mem_resp_valid)        w_next_state = ST_REQ1;
                else if (w_to_expire)      w_next_state = ST_REQ0;
            end
            ST_REQ1:   if (mem_req_ready)  w_next_state = ST_WAIT1;
            ST_WAIT1: begin
                if (mem_resp_valid)        w_next_state = ST_FILL;
                else if (w_to_expire)      w_next_state = ST_REQ1;
            end
            ST_FILL:                       w_next_state = ST_SETTLE;
            ST_SETTLE:                     w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_data0    <= '0;
            r_data1    <= '0;
            r_to_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_miss) begin
                r_base     <= {cpu_r_addr[31:2], 2'b00};
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
            // A response or an expiry both end the wait, so the next wait starts from zero.
            if (w_in_wait) begin
                if (mem_resp_valid || w_to_expire) begin
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + c_to_w'(1);
                end
            end
            if ((r_state == ST_WAIT0) && mem_resp_valid) begin
                r_data0 <= mem_resp_data;
            end
            if ((r_state == ST_WAIT1) && mem_resp_valid) begin
                r_data1 <= mem_resp_data;
            end
        end
    end

endmodule
`default_nettype wire
